// File: rtl/ef_smsdac_dec_pkg.sv
// ef_smsdac_dec_pkg: shared constants, usage-FSM states and helpers for the element decoder/checker.
package ef_smsdac_dec_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_SCAN, ST_DONE} state_t;
    localparam int DEF_ENC_LAT  = 1;
    localparam int DEF_WIN_LOG2 = 8;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/ef_smsdac_popcnt.sv
// ef_smsdac_popcnt: combinational population count of N unit-element bits.
module ef_smsdac_popcnt #(
    parameter int N = 15,
    parameter int W = 4
) (
    input  logic [N-1:0] i_bits,
    output logic [W-1:0] o_cnt
);
    always_comb begin
        o_cnt = '0;
        for (int k = 0; k < N; k++) o_cnt = o_cnt + W'(i_bits[k]);
    end
endmodule

// File: rtl/ef_smsdac_dec.sv
// ef_smsdac_dec: decodes the element vector by popcount, checks it against the aligned
// encoder code, and measures windowed element-usage spread.
module ef_smsdac_dec
    import ef_smsdac_dec_pkg::*;
#(
    parameter int BITS     = 4,
    parameter int N_ELEM   = 2**BITS-1,
    parameter int ENC_LAT  = DEF_ENC_LAT,
    parameter int WIN_LOG2 = DEF_WIN_LOG2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic [BITS-1:0]     i_x,
    input  logic [N_ELEM-1:0]   i_elem,
    input  logic                i_start,
    output logic [BITS-1:0]     o_sum,
    output logic                o_mismatch,
    output logic                o_err_sticky,
    output logic [7:0]          o_err_cnt,
    output logic                o_busy,
    output logic                o_done,
    output logic [WIN_LOG2:0]   o_spread
);
    localparam int CW  = WIN_LOG2 + 1;
    localparam int WIN = 1 << WIN_LOG2;
    localparam int IW  = clog2(N_ELEM) > 0 ? clog2(N_ELEM) : 1;

    logic [BITS-1:0] pc, x_al;
    logic            vld;

    ef_smsdac_popcnt #(.N(N_ELEM), .W(BITS)) u_popcnt (.i_bits(i_elem), .o_cnt(pc));

    if (ENC_LAT == 0) begin : g_wire
        assign x_al = i_x;
        assign vld  = 1'b1;
    end else begin : g_dly
        logic [BITS-1:0]    x_q [ENC_LAT];
        logic [ENC_LAT-1:0] v_q;
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                x_q <= '{default: '0};
                v_q <= '0;
            end else begin
                x_q[0] <= i_x;
                for (int k = 1; k < ENC_LAT; k++) x_q[k] <= x_q[k-1];
                v_q <= (v_q << 1) | ENC_LAT'(1);
            end
        end
        assign x_al = x_q[ENC_LAT-1];
        assign vld  = v_q[ENC_LAT-1];
    end

    logic            mis_d, sticky_d;
    logic [7:0]      err_d;
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q [N_ELEM];
    logic [CW-1:0]   cnt_d [N_ELEM];
    logic [CW-1:0]   cyc_q, cyc_d, max_q, max_d, min_q, min_d, spread_d, cur;
    logic [IW-1:0]   idx_q, idx_d;
    logic            done_d;

    always_comb begin
        mis_d    = i_en & vld & (pc != x_al);
        sticky_d = o_err_sticky | mis_d;
        err_d    = (mis_d && o_err_cnt != 8'hff) ? o_err_cnt + 8'd1 : o_err_cnt;
    end

    // Usage window: accumulate per-element hits, then walk the counters for max/min.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cyc_d    = cyc_q;
        idx_d    = idx_q;
        max_d    = max_q;
        min_d    = min_q;
        spread_d = o_spread;
        done_d   = 1'b0;
        cur      = cnt_q[idx_q];
        case (state_q)
            ST_IDLE: if (i_start) begin
                state_d = ST_ACCUM;
                cnt_d   = '{default: '0};
                cyc_d   = '0;
            end
            ST_ACCUM: begin
                for (int k = 0; k < N_ELEM; k++) cnt_d[k] = cnt_q[k] + CW'(i_elem[k]);
                cyc_d   = cyc_q + 1'b1;
                idx_d   = '0;
                state_d = (cyc_q == CW'(WIN - 1)) ? ST_SCAN : ST_ACCUM;
            end
            ST_SCAN: begin
                max_d   = (idx_q == '0 || cur > max_q) ? cur : max_q;
                min_d   = (idx_q == '0 || cur < min_q) ? cur : min_q;
                idx_d   = idx_q + 1'b1;
                state_d = (idx_q == IW'(N_ELEM - 1)) ? ST_DONE : ST_SCAN;
            end
            ST_DONE: begin
                spread_d = max_q - min_q;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_sum        <= '0;
            o_mismatch   <= 1'b0;
            o_err_sticky <= 1'b0;
            o_err_cnt    <= '0;
            state_q      <= ST_IDLE;
            cnt_q        <= '{default: '0};
            cyc_q        <= '0;
            idx_q        <= '0;
            max_q        <= '0;
            min_q        <= '0;
            o_spread     <= '0;
            o_done       <= 1'b0;
        end else begin
            o_sum        <= pc;
            o_mismatch   <= mis_d;
            o_err_sticky <= sticky_d;
            o_err_cnt    <= err_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cyc_q        <= cyc_d;
            idx_q        <= idx_d;
            max_q        <= max_d;
            min_q        <= min_d;
            o_spread     <= spread_d;
            o_done       <= done_d;
        end
    end

    assign o_busy = (state_q != ST_IDLE);
endmodule

// File: tb/tb_ef_smsdac_dec.sv
// tb_ef_smsdac_dec: directed plus randomized checks of decode, mismatch counting and the
// usage-spread window against a cycle-indexed reference model.
module tb_ef_smsdac_dec;
    localparam int BITS  = 4;
    localparam int NE    = 15;
    localparam int LAT   = 1;
    localparam int WL    = 4;
    localparam int WIN   = 16;
    localparam int SCANC = NE;

    logic          i_clk = 1'b0, i_rst = 1'b0, i_en = 1'b0, i_start = 1'b0;
    logic [3:0]    i_x = '0;
    logic [14:0]   i_elem = '0;
    logic [3:0]    o_sum;
    logic          o_mismatch, o_err_sticky, o_busy, o_done;
    logic [7:0]    o_err_cnt;
    logic [WL:0]   o_spread;

    ef_smsdac_dec #(.BITS(BITS), .N_ELEM(NE), .ENC_LAT(LAT), .WIN_LOG2(WL)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_x(i_x), .i_elem(i_elem),
        .i_start(i_start), .o_sum(o_sum), .o_mismatch(o_mismatch),
        .o_err_sticky(o_err_sticky), .o_err_cnt(o_err_cnt), .o_busy(o_busy),
        .o_done(o_done), .o_spread(o_spread)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, ws = -1000, since = 0, done_at = -1;
    int e_sum = 0, e_cnt = 0, e_spread = 0;
    bit e_mis = 0, e_sticky = 0, e_busy = 0, e_done = 0;
    logic [3:0] x_prev = '0;
    int usage [NE];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [14:0] therm(input int v);
        logic [15:0] t;
        t = (16'd1 << v) - 16'd1;
        return t[14:0];
    endfunction

    // Model: window started at cycle ws samples cycles ws+1..ws+16, is busy until ws+32,
    // and reports at ws+33; the FSM accepts a start only once that report cycle is reached.
    task automatic cycle(input logic [3:0] x, input logic [14:0] e, input logic en, input logic st);
        int mx, mn;
        i_x = x; i_elem = e; i_en = en; i_start = st;
        if (st && cyc > ws + 1 + WIN + SCANC) begin
            ws = cyc;
            foreach (usage[k]) usage[k] = 0;
        end
        if (cyc >= ws + 1 && cyc <= ws + WIN)
            foreach (usage[k]) usage[k] += int'(e[k]);
        e_sum = $countones(e);
        e_mis = en && since >= LAT && (e_sum != int'(x_prev));
        if (e_mis) begin
            e_sticky = 1;
            if (e_cnt < 255) e_cnt++;
        end
        x_prev = x; since++; cyc++;
        e_busy = (cyc >= ws + 1) && (cyc <= ws + 1 + WIN + SCANC);
        e_done = (cyc == ws + 2 + WIN + SCANC);
        if (e_done) begin
            mx = usage[0]; mn = usage[0];
            foreach (usage[k]) begin
                if (usage[k] > mx) mx = usage[k];
                if (usage[k] < mn) mn = usage[k];
            end
            e_spread = mx - mn;
        end
        @(posedge i_clk); #1;
        chk("sum", 32'(o_sum), 32'(e_sum));
        chk("mismatch", 32'(o_mismatch), 32'(e_mis));
        chk("sticky", 32'(o_err_sticky), 32'(e_sticky));
        chk("err_cnt", 32'(o_err_cnt), 32'(e_cnt));
        chk("busy", 32'(o_busy), 32'(e_busy));
        chk("done", 32'(o_done), 32'(e_done));
        chk("spread", 32'(o_spread), 32'(e_spread));
        if (o_done) done_at = cyc;
    endtask

    task automatic do_reset();
        i_rst = 1'b1; i_start = 1'b0;
        #1;
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_spread", 32'(o_spread), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_cnt", 32'(o_err_cnt), 0);
        chk("rst_sticky", 32'(o_err_sticky), 0);
        chk("rst_mis", 32'(o_mismatch), 0);
        chk("rst_sum", 32'(o_sum), 0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        ws = -1000; since = 0; x_prev = '0;
        e_sticky = 0; e_cnt = 0; e_spread = 0; e_sum = 0; e_mis = 0;
    endtask

    initial begin
        logic [3:0] px, nx;
        logic [3:0] seq [4];
        int c0;
        seq = '{4'd5, 4'd10, 4'd15, 4'd0};
        #2;
        do_reset();
        px = '0;
        foreach (seq[i]) begin
            cycle(seq[i], therm(int'(px)), 1'b1, 1'b0);
            px = seq[i];
        end
        cycle(4'd5, therm(int'(px)), 1'b1, 1'b0);
        cycle(4'd0, therm(6), 1'b1, 1'b0);
        cycle(4'd5, therm(0), 1'b1, 1'b0);
        cycle(4'd0, therm(6), 1'b0, 1'b0);
        cycle(4'd0, therm(0), 1'b1, 1'b0);
        px = '0;
        for (int i = 0; i < 60; i++) begin
            nx = 4'($urandom_range(0, 15));
            cycle(nx, ($urandom_range(0, 3) != 0) ? therm(int'(px)) : 15'($urandom),
                  1'($urandom_range(0, 1)), 1'b0);
            px = nx;
        end
        for (int i = 0; i < 300; i++) cycle(4'd0, therm(1), 1'b1, 1'b0);
        chk("sat_cnt", 32'(o_err_cnt), 255);
        chk("sat_sticky", 32'(o_err_sticky), 1);
        do_reset();
        c0 = cyc; done_at = -1;
        cycle(4'd0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) cycle(4'd0, 15'h7fff, 1'b0, 1'b0);
        chk("done_latency", 32'(done_at - c0), 33);
        c0 = cyc;
        cycle(4'd0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) cycle(4'd1, 15'h0001, 1'b0, 1'b0);
        chk("spread_one_elem", 32'(o_spread), 16);
        c0 = cyc;
        cycle(4'd0, '0, 1'b0, 1'b1);
        for (int i = 1; i <= 40; i++)
            cycle(4'($urandom), 15'($urandom), 1'($urandom_range(0, 1)), 1'(i == 20 || i == 32));
        for (int i = 0; i < 40; i++)
            cycle(4'($urandom), 15'($urandom), 1'b1, 1'($urandom_range(0, 7) == 0));
        cycle(4'd0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(4'd0, 15'h00ff, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 40; i++) cycle(4'd0, 15'h00ff, 1'b0, 1'b0);
        done_at = -1;
        cycle(4'd0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) cycle(4'd0, 15'h00ff, 1'b0, 1'b0);
        chk("fresh_done_seen", 32'(done_at >= 0), 1);
        chk("fresh_spread", 32'(o_spread), 16);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
